// File: rtl/dcache_pkg.sv
// rtl/dcache_pkg.sv - shared types and geometry constants for the data cache responder
package dcache_pkg;
  localparam int NUM_SETS   = 16;
  localparam int LINE_WORDS = 4;
  localparam int OFFSET_W   = $clog2(LINE_WORDS);
  localparam int INDEX_W    = $clog2(NUM_SETS);
  localparam int TAG_W      = 32 - INDEX_W - OFFSET_W - 2;

  typedef logic [32*LINE_WORDS-1:0] line_t;

  typedef enum logic [1:0] {
    IDLE,
    WB_REQ,
    ALLOC_REQ,
    ALLOC_WAIT
  } state_t;
endpackage

// File: rtl/dcache_array.sv
// rtl/dcache_array.sv - direct-mapped tag/valid/dirty/data store, combinational read, clocked write
module dcache_array
  import dcache_pkg::*;
#(
  parameter int IDX_W     = 4,
  parameter int TAG_BITS  = 24,
  parameter int LINE_BITS = 128
) (
  input  logic                 clk,
  input  logic                 reset,
  input  logic [IDX_W-1:0]     rd_idx,
  output logic                 rd_valid,
  output logic                 rd_dirty,
  output logic [TAG_BITS-1:0]  rd_tag,
  output logic [LINE_BITS-1:0] rd_data,
  input  logic                 wr_en,
  input  logic [IDX_W-1:0]     wr_idx,
  input  logic                 wr_dirty,
  input  logic [TAG_BITS-1:0]  wr_tag,
  input  logic [LINE_BITS-1:0] wr_data
);
  localparam int SETS = 1 << IDX_W;

  logic [SETS-1:0]      valid_q;
  logic [SETS-1:0]      dirty_q;
  logic [TAG_BITS-1:0]  tag_q  [SETS];
  logic [LINE_BITS-1:0] data_q [SETS];

  assign rd_valid = valid_q[rd_idx];
  assign rd_dirty = dirty_q[rd_idx];
  assign rd_tag   = tag_q[rd_idx];
  assign rd_data  = data_q[rd_idx];

  // Every write leaves the line valid; reset wins over a same-cycle write.
  always_ff @(posedge clk) begin
    if (reset) begin
      valid_q <= '0;
      dirty_q <= '0;
    end else if (wr_en) begin
      valid_q[wr_idx] <= 1'b1;
      dirty_q[wr_idx] <= wr_dirty;
    end
  end

  always_ff @(posedge clk) begin
    if (wr_en) begin
      tag_q[wr_idx]  <= wr_tag;
      data_q[wr_idx] <= wr_data;
    end
  end
endmodule

// File: rtl/dcache_responder.sv
// rtl/dcache_responder.sv - write-back write-allocate cache FSM; optional DCACHE_STATS_EN counters
module dcache_responder #(
  parameter int NUM_SETS   = 16,
  parameter int LINE_WORDS = 4
) (
  input  logic                    clk,
  input  logic                    reset,
  input  logic                    is_input_valid,
  input  logic [31:0]             addr,
  input  logic [31:0]             din,
  input  logic                    mem_read,
  input  logic                    mem_write,
  output logic                    is_ready,
  output logic                    is_output_valid,
  output logic                    is_hit,
  output logic [31:0]             dout,
  output logic                    mem_req_valid,
  output logic                    mem_req_write,
  output logic [31:0]             mem_req_addr,
  output logic [32*LINE_WORDS-1:0] mem_req_data,
  input  logic                    mem_req_ready,
  input  logic                    mem_resp_valid,
  input  logic [32*LINE_WORDS-1:0] mem_resp_data
`ifdef DCACHE_STATS_EN
  ,
  output logic [31:0]             access_count,
  output logic [31:0]             miss_count
`endif
);
  import dcache_pkg::*;

  localparam int OFF_W     = $clog2(LINE_WORDS);
  localparam int IDX_W     = $clog2(NUM_SETS);
  localparam int TG_W      = 30 - OFF_W - IDX_W;
  localparam int LINE_BITS = 32 * LINE_WORDS;

  state_t state_q, state_d;

  logic [IDX_W-1:0]     idx;
  logic [OFF_W-1:0]     off;
  logic [TG_W-1:0]      req_tag;
  logic                 rd_valid, rd_dirty, tag_match, lookup_hit;
  logic [TG_W-1:0]      rd_tag;
  logic [LINE_BITS-1:0] rd_data, store_line, wr_data;
  logic [31:0]          word;
  logic                 wr_en, wr_dirty;
  logic                 unused_inputs;

  assign idx     = addr[2+OFF_W +: IDX_W];
  assign off     = addr[2 +: OFF_W];
  assign req_tag = addr[31 -: TG_W];
  // Byte lanes are ignored and a read+write request behaves as a store.
  assign unused_inputs = ^{addr[1:0], mem_read};

  dcache_array #(
    .IDX_W    (IDX_W),
    .TAG_BITS (TG_W),
    .LINE_BITS(LINE_BITS)
  ) u_array (
    .clk     (clk),
    .reset   (reset),
    .rd_idx  (idx),
    .rd_valid(rd_valid),
    .rd_dirty(rd_dirty),
    .rd_tag  (rd_tag),
    .rd_data (rd_data),
    .wr_en   (wr_en),
    .wr_idx  (idx),
    .wr_dirty(wr_dirty),
    .wr_tag  (req_tag),
    .wr_data (wr_data)
  );

  assign tag_match  = rd_valid && (rd_tag == req_tag);
  assign lookup_hit = (state_q == IDLE) && is_input_valid && tag_match;
  assign word       = rd_data[{off, 5'b0} +: 32];

  always_comb begin
    store_line = rd_data;
    store_line[{off, 5'b0} +: 32] = din;
  end

  // Stores hit in IDLE; fills land in ALLOC_WAIT. The held address selects the set in both.
  assign wr_en    = (lookup_hit && mem_write) || ((state_q == ALLOC_WAIT) && mem_resp_valid);
  assign wr_dirty = (state_q == IDLE);
  assign wr_data  = (state_q == IDLE) ? store_line : mem_resp_data;

  always_ff @(posedge clk) begin
    if (reset) state_q <= IDLE;
    else       state_q <= state_d;
  end

  always_comb begin
    state_d       = state_q;
    is_ready      = 1'b0;
    is_hit        = 1'b0;
    mem_req_valid = 1'b0;
    mem_req_write = 1'b0;
    mem_req_addr  = '0;
    mem_req_data  = '0;
    case (state_q)
      IDLE: begin
        is_ready = 1'b1;
        is_hit   = lookup_hit;
        if (is_input_valid && !tag_match)
          state_d = (rd_valid && rd_dirty) ? WB_REQ : ALLOC_REQ;
      end
      WB_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_write = 1'b1;
        mem_req_addr  = {rd_tag, idx, {(OFF_W+2){1'b0}}};
        mem_req_data  = rd_data;
        if (mem_req_ready) state_d = ALLOC_REQ;
      end
      ALLOC_REQ: begin
        mem_req_valid = 1'b1;
        mem_req_addr  = {addr[31:OFF_W+2], {(OFF_W+2){1'b0}}};
        if (mem_req_ready) state_d = ALLOC_WAIT;
      end
      ALLOC_WAIT: begin
        if (mem_resp_valid) state_d = IDLE;
      end
      default: state_d = IDLE;
    endcase
  end

  assign is_output_valid = is_hit;
  assign dout            = is_hit ? word : 32'h0;

`ifdef DCACHE_STATS_EN
  always_ff @(posedge clk) begin
    if (reset) begin
      access_count <= '0;
      miss_count   <= '0;
    end else begin
      if (is_output_valid) access_count <= access_count + 32'd1;
      if ((state_q == IDLE) && (state_d != IDLE)) miss_count <= miss_count + 32'd1;
    end
  end
`endif
endmodule

// File: tb/tb_dcache_responder.sv
// tb/tb_dcache_responder.sv - directed and randomized checks of dcache_responder against a line-level model
module tb_dcache_responder;
  import dcache_pkg::*;

  logic        clk = 1'b0;
  logic        reset, is_input_valid, mem_read, mem_write;
  logic [31:0] addr, din, dout, mem_req_addr;
  logic        is_ready, is_output_valid, is_hit;
  logic        mem_req_valid, mem_req_write, mem_req_ready, mem_resp_valid;
  line_t       mem_req_data, mem_resp_data;
`ifdef DCACHE_STATS_EN
  logic [31:0] access_count, miss_count;
`endif

  always #5 clk = ~clk;

  dcache_responder dut (
    .clk(clk), .reset(reset), .is_input_valid(is_input_valid), .addr(addr), .din(din),
    .mem_read(mem_read), .mem_write(mem_write), .is_ready(is_ready),
    .is_output_valid(is_output_valid), .is_hit(is_hit), .dout(dout),
    .mem_req_valid(mem_req_valid), .mem_req_write(mem_req_write), .mem_req_addr(mem_req_addr),
    .mem_req_data(mem_req_data), .mem_req_ready(mem_req_ready), .mem_resp_valid(mem_resp_valid),
    .mem_resp_data(mem_resp_data)
`ifdef DCACHE_STATS_EN
    , .access_count(access_count), .miss_count(miss_count)
`endif
  );

  // Reference: cache contents per set plus a sparse backing memory keyed by line address.
  bit          m_valid [16];
  bit          m_dirty [16];
  logic [23:0] m_tag   [16];
  line_t       m_line  [16];
  line_t       backing [logic [31:0]];
  int          tests = 0, fails = 0, exp_acc = 0, exp_miss = 0;

  task automatic chk(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    tests++;
    assert (obs === exp) else begin
      fails++;
      $error("FAIL %s: observed %0h expected %0h", tag, obs, exp);
    end
  endtask

  function automatic line_t mem_line(input logic [31:0] la);
    if (backing.exists(la)) return backing[la];
    return {~la, la + 32'h3000, la * 3, la ^ 32'hCAFE_0000};
  endfunction

  task automatic model_clear();
    for (int i = 0; i < 16; i++) begin
      m_valid[i] = 1'b0;
      m_dirty[i] = 1'b0;
    end
    exp_acc  = 0;
    exp_miss = 0;
  endtask

  task automatic do_reset();
    reset = 1'b1;
    is_input_valid = 1'b0;
    @(negedge clk);
    chk("rst_ready", is_ready, 1);
    chk("rst_hit", is_hit, 0);
    chk("rst_ov", is_output_valid, 0);
    chk("rst_dout", dout, 0);
    chk("rst_req_valid", mem_req_valid, 0);
    chk("rst_req_write", mem_req_write, 0);
    chk("rst_req_addr", mem_req_addr, 0);
    reset = 1'b0;
    model_clear();
  endtask

  // Entered at a negedge in a request state; holds ready low for dly cycles, then accepts.
  task automatic serve_req(input bit wr, input logic [31:0] a, input line_t data, input int dly);
    for (int i = 0; i <= dly; i++) begin
      chk("req_valid", mem_req_valid, 1);
      chk("req_write", mem_req_write, wr);
      chk("req_addr", mem_req_addr, a);
      if (wr) chk("req_data", mem_req_data, data);
      chk("req_not_ready", is_ready, 0);
      chk("req_no_hit", {is_hit, is_output_valid}, 0);
      mem_resp_valid = 1'($urandom_range(0, 1));
      mem_resp_data  = {$urandom, $urandom, $urandom, $urandom};
      mem_req_ready  = (i == dly);
      @(negedge clk);
      mem_req_ready  = 1'b0;
      mem_resp_valid = 1'b0;
    end
  endtask

  task automatic access(input logic [31:0] a, input logic [31:0] d, input bit rd, input bit wr,
                        input int rdy_dly, input int resp_dly);
    logic [3:0]  si;
    logic [23:0] tg;
    int          off;
    line_t       ln;
    si  = a[7:4];
    tg  = a[31:8];
    off = int'(a[3:2]);
    addr = a; din = d; mem_read = rd; mem_write = wr; is_input_valid = 1'b1;
    #1;
    if (!(m_valid[si] && m_tag[si] == tg)) begin
      chk("miss_hit", is_hit, 0);
      chk("miss_ov", is_output_valid, 0);
      chk("miss_dout", dout, 0);
      chk("miss_ready", is_ready, 1);
      exp_miss++;
      @(negedge clk);
      if (m_valid[si] && m_dirty[si]) begin
        serve_req(1'b1, {m_tag[si], si, 4'h0}, m_line[si], rdy_dly);
        backing[{m_tag[si], si, 4'h0}] = m_line[si];
      end
      serve_req(1'b0, {a[31:4], 4'h0}, '0, rdy_dly);
      for (int i = 0; i < resp_dly; i++) begin
        chk("wait_not_ready", is_ready, 0);
        chk("wait_no_req", mem_req_valid, 0);
        @(negedge clk);
      end
      ln = mem_line({a[31:4], 4'h0});
      mem_resp_valid = 1'b1;
      mem_resp_data  = ln;
      @(negedge clk);
      mem_resp_valid = 1'b0;
      m_valid[si] = 1'b1;
      m_dirty[si] = 1'b0;
      m_tag[si]   = tg;
      m_line[si]  = ln;
    end
    chk("hit_ready", is_ready, 1);
    chk("hit", is_hit, 1);
    chk("hit_ov", is_output_valid, 1);
    chk("hit_no_req", mem_req_valid, 0);
    if (!wr) chk("hit_dout", dout, m_line[si][off*32 +: 32]);
    exp_acc++;
    if (wr) begin
      m_line[si][off*32 +: 32] = d;
      m_dirty[si] = 1'b1;
    end
    @(negedge clk);
    is_input_valid = 1'b0; mem_read = 1'b0; mem_write = 1'b0;
    #1;
    chk("after_ov", is_output_valid, 0);
    chk("after_dout", dout, 0);
  endtask

  initial begin
    reset = 1'b1; is_input_valid = 1'b0; addr = '0; din = '0;
    mem_read = 1'b0; mem_write = 1'b0; mem_req_ready = 1'b0;
    mem_resp_valid = 1'b0; mem_resp_data = '0;
    @(negedge clk);
    do_reset();

    backing[32'h10] = {32'h44, 32'h33, 32'h22, 32'h11};
    access(32'h0000_0010, 32'h0, 1, 0, 0, 1);
`ifdef DCACHE_STATS_EN
    chk("first_miss_count", miss_count, 1);
`endif
    access(32'h0000_0014, 32'hDEAD_BEEF, 0, 1, 0, 0);
    access(32'h0000_0014, 32'h0, 1, 0, 0, 0);
    access(32'h0000_0110, 32'h0, 1, 0, 5, 2);
    access(32'h0000_0110, 32'h5, 1, 1, 0, 0);
    access(32'h0000_0010, 32'h0, 1, 0, 1, 0);

    // No request: nothing happens even with a store pending on the pins.
    addr = 32'h0000_0110; mem_write = 1'b1; din = 32'hFFFF_FFFF;
    for (int i = 0; i < 3; i++) begin
      @(negedge clk);
      chk("idle_no_hit", {is_hit, is_output_valid, mem_req_valid}, 0);
      chk("idle_ready", is_ready, 1);
    end
    mem_write = 1'b0;
    access(32'h0000_0018, 32'h0, 1, 0, 0, 0);

    for (int n = 0; n < 200; n++) begin
      logic [31:0] ra;
      ra = {22'($urandom_range(0, 3)), 4'($urandom_range(0, 15)), 4'($urandom_range(0, 15)), 2'b00};
      access(ra, $urandom, 1'($urandom_range(0, 1)), 1'($urandom_range(0, 1)),
             $urandom_range(0, 3), $urandom_range(0, 2));
    end

    // Reset while waiting for the fill: the late response must not install anything.
    do_reset();
    addr = 32'h10; mem_read = 1'b1; is_input_valid = 1'b1;
    @(negedge clk);
    chk("abort_alloc_addr", mem_req_addr, 32'h10);
    chk("abort_alloc_write", mem_req_write, 0);
    mem_req_ready = 1'b1;
    @(negedge clk);
    mem_req_ready = 1'b0;
    chk("abort_wait_ready", is_ready, 0);
    reset = 1'b1; is_input_valid = 1'b0; mem_read = 1'b0;
    @(negedge clk);
    reset = 1'b0;
    model_clear();
    mem_resp_valid = 1'b1;
    mem_resp_data  = {4{32'hBAD0_BAD0}};
    @(negedge clk);
    mem_resp_valid = 1'b0;
    chk("abort_idle_ready", is_ready, 1);
    access(32'h0000_0010, 32'h0, 1, 0, 0, 0);

`ifdef DCACHE_STATS_EN
    chk("access_count", access_count, exp_acc);
    chk("miss_count", miss_count, exp_miss);
`endif
    $display("[TB] %0d tests run, %0d failed", tests, fails);
    $finish;
  end

  initial begin
    #2_000_000;
    $display("FAIL timeout: simulation did not finish");
    $fatal(1, "timeout");
  end
endmodule
